piso_tx_ctrl: RTL and testbench
===============================

Name: piso_tx_ctrl

Overview:
- Serial-transmit sequencer for the team's parallel-in/serial-out shift register.
- Accepts DATA_W-bit words from an upstream producer over a valid/ready handshake.
- Generates the load and shift strobes for an internal PISO, holding each bit for BIT_DIV clocks.
- Emits the framed serial stream with start/last markers, with optional inter-frame idle gap. Sits between a byte source (FIFO/CPU port) and a serial line driver.

Parameters:
- DATA_W, 8, word width and bits per frame (>=2).
- BIT_DIV, 1, clocks each bit is held on ser_out (>=1).
- GAP_CYCLES, 0, idle clocks forced between frames (>=0).
- MSB_FIRST, 1, 1 = shift out bit DATA_W-1 first; 0 = bit 0 first.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  parallel word to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller can accept a word this cycle.
- ser_out  out  1  serial bit; 0 when not transmitting.
- ser_valid  out  1  ser_out carries a frame bit.
- frame_start  out  1  high for all cycles of bit 0 of a frame.
- frame_last  out  1  high for all cycles of the final bit of a frame.
- busy  out  1  state != IDLE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, bit_cnt=0, div_cnt=0, gap_cnt=0, shift reg=0, ser_out=0, ser_valid=0, frame_start=0, frame_last=0, busy=0. in_ready is forced 0 in any cycle rst=1.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready: load pulse to the PISO, bit_cnt<=0, div_cnt<=0, go SHIFT.
  - Accept cycle N -> bit 0 on ser_out in cycle N+1 (latency 1).
- SHIFT:
  - ser_valid=1; ser_out = PISO output bit.
  - div_cnt counts 0..BIT_DIV-1. At div_cnt==BIT_DIV-1: div_cnt<=0 and either shift the PISO and bit_cnt++ (not last bit), or finish the frame (last bit).
  - Frame length = DATA_W*BIT_DIV cycles exactly.
- End of frame (bit_cnt==DATA_W-1 && div_cnt==BIT_DIV-1):
  - GAP_CYCLES>0: go GAP, gap_cnt<=0; in_ready=0 this cycle.
  - GAP_CYCLES==0: in_ready=1 in this final cycle. If in_valid, load the new word and stay in SHIFT with counters cleared, giving zero idle cycles between frames; else go IDLE.
- In all other SHIFT cycles: in_ready=0; in_data/in_valid ignored.
- GAP:
  - ser_out=0, ser_valid=0, in_ready=0.
  - Counts GAP_CYCLES clocks, then goes IDLE; the next word can be accepted on the following cycle.
- frame_start / frame_last: qualified by ser_valid. With DATA_W>=2 they are never high together.
- Bit order: MSB_FIRST=1 emits in_data[DATA_W-1] down to [0]; MSB_FIRST=0 emits [0] up to [DATA_W-1].
- Reset mid-frame: the frame is aborted; outputs return to reset values on the next edge; the remaining bits are never sent.
- in_valid dropped before acceptance: no effect (no latch without handshake).
- Counter widths: $clog2 of max count, minimum 1 bit.

Decomposition:
- Package piso_ctrl_pkg: state typedef (IDLE/SHIFT/GAP) and SER_IDLE_LVL=1'b0.
- Sub-module piso_shreg holds the shift register, parameters DATA_W and MSB_FIRST:
  - ports: clk, rst, load, shift_en, data_in, ser_bit.
  - load has priority over shift_en.
  - zero-fill on shift.

Test Plan:
- DATA_W=8, BIT_DIV=2, MSB_FIRST=1, send 0xA5 -> ser_out 1,0,1,0,0,1,0,1, each held 2 cycles; ser_valid high 16 cycles; frame_start cycles 1-2, frame_last cycles 15-16; busy then 0.
- GAP=0, in_valid held with 0xA5 then 0x3C -> in_ready pulses in frame cycle 16; 0x3C bit 0 (0) follows with no idle cycle; 32 contiguous ser_valid cycles.
- GAP_CYCLES=3, two back-to-back words -> 3 cycles ser_valid=0 plus 1 IDLE accept cycle between frames; in_ready=0 throughout GAP.
- MSB_FIRST=0, BIT_DIV=1, send 0x01 -> ser_out 1 then seven 0s; frame occupies exactly 8 cycles.
- rst=1 during bit 3 of 0xFF -> next cycle ser_out=0, ser_valid=0, busy=0, in_ready=0 while rst high, 1 after release; the new word 0x80 transmits correctly.
- in_valid=1 while mid-frame (GAP=0, not final cycle) -> word not consumed; in_ready stays 0 until the final bit cycle.

Source files
------------

// File: rtl/piso_tx_ctrl_pkg.sv
// piso_ctrl_pkg: shared types and constants for the PISO transmit controller.
//   state_t      - controller FSM states (IDLE / SHIFT / GAP)
//   SER_IDLE_LVL - level driven on ser_out when no frame bit is present
package piso_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic SER_IDLE_LVL = 1'b0;

endpackage : piso_ctrl_pkg

// File: rtl/piso_tx_ctrl_if.sv
// piso_tx_ctrl_if: word handshake plus framed serial outputs of piso_tx_ctrl.
//   in_data/in_valid/in_ready - upstream valid/ready word port
//   ser_out/ser_valid         - serial bit and its qualifier
//   frame_start/frame_last    - markers for first / final bit of a frame
//   busy                      - controller not idle
// master: producer/observer side; slave: the controller.
interface piso_tx_ctrl_if #(
   parameter int unsigned DATA_W = 8
);

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              ser_out;
   logic              ser_valid;
   logic              frame_start;
   logic              frame_last;
   logic              busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, ser_out, ser_valid, frame_start, frame_last, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, ser_out, ser_valid, frame_start, frame_last, busy
   );

endinterface : piso_tx_ctrl_if

// File: rtl/piso_tx_ctrl_shreg.sv
// piso_shreg: parallel-in/serial-out shift register.
//   clk, rst  - clock, synchronous active-high reset (clears register)
//   load      - capture data_in (wins over shift_en)
//   shift_en  - advance one bit, zero-filling the vacated end
//   data_in   - parallel word
//   ser_bit   - current serial bit (MSB or LSB depending on MSB_FIRST)
module piso_shreg #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] data_in,
   output logic              ser_bit
);

   logic [DATA_W-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= data_in;
      end else if (shift_en) begin
         if (MSB_FIRST != 0) sr <= {sr[DATA_W-2:0], 1'b0};
         else                sr <= {1'b0, sr[DATA_W-1:1]};
      end
   end

   assign ser_bit = (MSB_FIRST != 0) ? sr[DATA_W-1] : sr[0];

endmodule : piso_shreg

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: serial-transmit sequencer around piso_shreg.
//   clk  - system clock (rising edge)
//   rst  - synchronous active-high reset
//   bus  - piso_tx_ctrl_if.slave: in_data/in_valid/in_ready word handshake,
//          ser_out/ser_valid serial stream, frame_start/frame_last markers,
//          busy status.
// Each accepted word becomes a frame of DATA_W bits, each held BIT_DIV
// clocks, optionally followed by GAP_CYCLES idle clocks.
module piso_tx_ctrl #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned BIT_DIV    = 1,
   parameter int unsigned GAP_CYCLES = 0,
   parameter int unsigned MSB_FIRST  = 1
) (
   input logic           clk,
   input logic           rst,
   piso_tx_ctrl_if.slave bus
);

   import piso_ctrl_pkg::*;

   localparam int unsigned BIT_W = (DATA_W > 1)     ? $clog2(DATA_W)     : 1;
   localparam int unsigned DIV_W = (BIT_DIV > 1)    ? $clog2(BIT_DIV)    : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t           state;
   logic [BIT_W-1:0] bit_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             ser_valid_q;
   logic             frame_start_q;
   logic             frame_last_q;
   logic             busy_q;

   logic             bit_end;
   logic             frame_end;
   logic             ready;
   logic             accept;
   logic             shift_en;
   logic             ser_bit;

   always_comb begin
      bit_end   = (div_cnt == DIV_LAST);
      frame_end = (state == SHIFT) && bit_end && (bit_cnt == BIT_LAST);
      // With no gap the final bit cycle doubles as the accept slot, so
      // frames can run back to back.
      ready     = !rst && ((state == IDLE) || ((GAP_CYCLES == 0) && frame_end));
      accept    = bus.in_valid && ready;
      shift_en  = (state == SHIFT) && bit_end && (bit_cnt != BIT_LAST);
   end

   piso_shreg #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .shift_en (shift_en),
      .data_in  (bus.in_data),
      .ser_bit  (ser_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         div_cnt       <= '0;
         gap_cnt       <= '0;
         ser_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_last_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state         <= SHIFT;
                  bit_cnt       <= '0;
                  div_cnt       <= '0;
                  ser_valid_q   <= 1'b1;
                  frame_start_q <= 1'b1;
                  frame_last_q  <= 1'b0;
                  busy_q        <= 1'b1;
               end
            end

            SHIFT: begin
               if (!bit_end) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (bit_cnt != BIT_LAST) begin
                     bit_cnt       <= bit_cnt + 1'b1;
                     frame_start_q <= 1'b0;
                     frame_last_q  <= ((bit_cnt + 1'b1) == BIT_LAST);
                  end else if (GAP_CYCLES > 0) begin
                     state        <= GAP;
                     gap_cnt      <= '0;
                     ser_valid_q  <= 1'b0;
                     frame_last_q <= 1'b0;
                  end else if (accept) begin
                     bit_cnt       <= '0;
                     frame_start_q <= 1'b1;
                     frame_last_q  <= 1'b0;
                  end else begin
                     state        <= IDLE;
                     ser_valid_q  <= 1'b0;
                     frame_last_q <= 1'b0;
                     busy_q       <= 1'b0;
                  end
               end
            end

            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = ready;
   assign bus.ser_valid   = ser_valid_q;
   assign bus.ser_out     = ser_valid_q ? ser_bit : SER_IDLE_LVL;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_last  = frame_last_q;
   assign bus.busy        = busy_q;

endmodule : piso_tx_ctrl

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl: directed checks of piso_tx_ctrl in three configurations.
//   u0: DATA_W=8 BIT_DIV=2 GAP=0 MSB first
//   u1: DATA_W=8 BIT_DIV=1 GAP=3 MSB first
//   u2: DATA_W=8 BIT_DIV=1 GAP=0 LSB first
module tb_piso_tx_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   piso_tx_ctrl_if #(.DATA_W(8)) b0 ();
   piso_tx_ctrl_if #(.DATA_W(8)) b1 ();
   piso_tx_ctrl_if #(.DATA_W(8)) b2 ();

   piso_tx_ctrl #(.DATA_W(8), .BIT_DIV(2), .GAP_CYCLES(0), .MSB_FIRST(1))
      u0 (.clk(clk), .rst(rst), .bus(b0));
   piso_tx_ctrl #(.DATA_W(8), .BIT_DIV(1), .GAP_CYCLES(3), .MSB_FIRST(1))
      u1 (.clk(clk), .rst(rst), .bus(b1));
   piso_tx_ctrl #(.DATA_W(8), .BIT_DIV(1), .GAP_CYCLES(0), .MSB_FIRST(0))
      u2 (.clk(clk), .rst(rst), .bus(b2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w;
      logic [7:0] wa;
      logic [7:0] wb;
      int         k;

      b0.in_data = '0; b0.in_valid = 1'b0;
      b1.in_data = '0; b1.in_valid = 1'b0;
      b2.in_data = '0; b2.in_valid = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst in_ready",  b0.in_ready,    0);
      check("rst ser_valid", b0.ser_valid,   0);
      check("rst ser_out",   b0.ser_out,     0);
      check("rst busy",      b0.busy,        0);
      check("rst fstart",    b0.frame_start, 0);
      check("rst flast",     b0.frame_last,  0);
      rst = 1'b0;
      #1;
      check("post-rst in_ready", b0.in_ready, 1);

      // T1: single 0xA5, BIT_DIV=2
      @(negedge clk);
      b0.in_data = 8'hA5; b0.in_valid = 1'b1;
      check("t1 accept ready", b0.in_ready, 1);
      w = 8'hA5;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("t1 sv[%0d]", i),    b0.ser_valid,   1);
         check($sformatf("t1 so[%0d]", i),    b0.ser_out,     w[7 - i/2]);
         check($sformatf("t1 fs[%0d]", i),    b0.frame_start, (i < 2)   ? 1 : 0);
         check($sformatf("t1 fl[%0d]", i),    b0.frame_last,  (i >= 14) ? 1 : 0);
         check($sformatf("t1 busy[%0d]", i),  b0.busy,        1);
         check($sformatf("t1 ready[%0d]", i), b0.in_ready,    (i == 15) ? 1 : 0);
         b0.in_valid = 1'b0;
      end
      @(negedge clk);
      check("t1 end sv",    b0.ser_valid, 0);
      check("t1 end so",    b0.ser_out,   0);
      check("t1 end busy",  b0.busy,      0);
      check("t1 end ready", b0.in_ready,  1);

      // T2: back-to-back 0xA5, 0x3C with GAP=0; in_valid held mid-frame
      b0.in_data = 8'hA5; b0.in_valid = 1'b1;
      wa = 8'hA5; wb = 8'h3C;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         w = (i < 16) ? wa : wb;
         k = i % 16;
         check($sformatf("t2 sv[%0d]", i),    b0.ser_valid,   1);
         check($sformatf("t2 so[%0d]", i),    b0.ser_out,     w[7 - k/2]);
         check($sformatf("t2 fs[%0d]", i),    b0.frame_start, (k < 2) ? 1 : 0);
         check($sformatf("t2 ready[%0d]", i), b0.in_ready,    (k == 15) ? 1 : 0);
         if (i == 0) b0.in_data = 8'h3C;
         if (i >= 16) b0.in_valid = 1'b0;
      end
      @(negedge clk);
      check("t2 end sv",   b0.ser_valid, 0);
      check("t2 end busy", b0.busy,      0);

      // T3: GAP_CYCLES=3, two words with in_valid held
      b1.in_data = 8'h5A; b1.in_valid = 1'b1;
      check("t3 accept ready", b1.in_ready, 1);
      wa = 8'h5A; wb = 8'hC3;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if ((i >= 1 && i <= 8) || (i >= 13 && i <= 20)) begin
            w = (i <= 8) ? wa : wb;
            k = (i <= 8) ? i - 1 : i - 13;
            check($sformatf("t3 sv[%0d]", i),    b1.ser_valid,   1);
            check($sformatf("t3 so[%0d]", i),    b1.ser_out,     w[7 - k]);
            check($sformatf("t3 fs[%0d]", i),    b1.frame_start, (k == 0) ? 1 : 0);
            check($sformatf("t3 fl[%0d]", i),    b1.frame_last,  (k == 7) ? 1 : 0);
            check($sformatf("t3 ready[%0d]", i), b1.in_ready,    0);
            check($sformatf("t3 busy[%0d]", i),  b1.busy,        1);
         end else if (i == 12 || i == 24) begin
            check($sformatf("t3 idle sv[%0d]", i),    b1.ser_valid, 0);
            check($sformatf("t3 idle ready[%0d]", i), b1.in_ready,  1);
            check($sformatf("t3 idle busy[%0d]", i),  b1.busy,      0);
         end else begin
            check($sformatf("t3 gap sv[%0d]", i),    b1.ser_valid, 0);
            check($sformatf("t3 gap so[%0d]", i),    b1.ser_out,   0);
            check($sformatf("t3 gap ready[%0d]", i), b1.in_ready,  0);
            check($sformatf("t3 gap busy[%0d]", i),  b1.busy,      1);
         end
         if (i == 1) b1.in_data = 8'hC3;
         if (i >= 13) b1.in_valid = 1'b0;
      end

      // T4: LSB first, BIT_DIV=1, 0x01
      @(negedge clk);
      b2.in_data = 8'h01; b2.in_valid = 1'b1;
      check("t4 accept ready", b2.in_ready, 1);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         b2.in_valid = 1'b0;
         if (i <= 8) begin
            check($sformatf("t4 sv[%0d]", i), b2.ser_valid,   1);
            check($sformatf("t4 so[%0d]", i), b2.ser_out,     (i == 1) ? 1 : 0);
            check($sformatf("t4 fs[%0d]", i), b2.frame_start, (i == 1) ? 1 : 0);
            check($sformatf("t4 fl[%0d]", i), b2.frame_last,  (i == 8) ? 1 : 0);
         end else begin
            check("t4 end sv",   b2.ser_valid, 0);
            check("t4 end busy", b2.busy,      0);
         end
      end

      // T5: reset during bit 3 of 0xFF, then send 0x80
      b0.in_data = 8'hFF; b0.in_valid = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         b0.in_valid = 1'b0;
         check($sformatf("t5 so[%0d]", i), b0.ser_out, 1);
      end
      rst = 1'b1;
      @(negedge clk);
      check("t5 rst so",    b0.ser_out,   0);
      check("t5 rst sv",    b0.ser_valid, 0);
      check("t5 rst busy",  b0.busy,      0);
      check("t5 rst ready", b0.in_ready,  0);
      rst = 1'b0;
      #1;
      check("t5 release ready", b0.in_ready, 1);
      b0.in_data = 8'h80; b0.in_valid = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         b0.in_valid = 1'b0;
         check($sformatf("t5 sv[%0d]", i), b0.ser_valid, 1);
         check($sformatf("t5 so[%0d]", i), b0.ser_out,   (i <= 2) ? 1 : 0);
      end
      @(negedge clk);
      check("t5 end sv",   b0.ser_valid, 0);
      check("t5 end busy", b0.busy,      0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_piso_tx_ctrl
